// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch unit.
//   state_t         : fetch FSM states
//   DEF_*           : localparams for the default configuration
//   instr_width()   : packed instruction word width for a configuration
//   len_code_width(): width of the length field in the opcode byte
//   len_from_opcode(): instruction length from the opcode's length field
package ifu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    SEND  = 2'd2
  } state_t;

  localparam int DEF_BYTE_W    = 8;
  localparam int DEF_MAX_BYTES = 2;
  localparam int DEF_INSTR_W   = DEF_MAX_BYTES * DEF_BYTE_W;
  localparam int DEF_LW        = $clog2(DEF_MAX_BYTES);

  function automatic int instr_width(input int byte_w, input int max_bytes);
    return byte_w * max_bytes;
  endfunction

  function automatic int len_code_width(input int max_bytes);
    return $clog2(max_bytes);
  endfunction

  // Length field holds len-1; codes beyond the widest instruction saturate.
  function automatic int len_from_opcode(input int len_code, input int max_bytes);
    if (len_code + 1 > max_bytes) return max_bytes;
    return len_code + 1;
  endfunction

endpackage

// File: rtl/ifu_lat_counter.sv
// Memory latency timer for one byte read.
//   clk      : clock
//   reset    : synchronous, active-low reset
//   load     : start timing a read (loads MEM_LAT)
//   flush    : abandon the read in flight
//   count_en : counting enabled (FSM is waiting on memory)
//   done     : this is the cycle at whose end mem_data is captured
module ifu_lat_counter #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic flush,
  input  logic count_en,
  output logic done
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 3'(MEM_LAT);
    end else if (count_en && cnt != '0) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Terminal count is 1 rather than 0 so the capture lands on the last wait cycle.
  assign done = count_en && (cnt == 3'd1);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch engine: reads variable-length instructions byte by byte
// from program memory, packs them MSB-first and hands them to the decoder.
//   clk, reset            : clock, synchronous active-low reset
//   enable                : allow a new instruction to start
//   jump_valid, jump_addr : redirect the program counter
//   mem_rd, mem_addr      : one-cycle read strobe and address per byte
//   mem_data              : read data, valid MEM_LAT cycles after mem_rd
//   dec_start, dec_ready  : decoder handshake
//   dec_instr             : packed instruction, opcode in MSBs
//   dec_len, dec_pc       : byte count and opcode address
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int BYTE_W    = DEF_BYTE_W,
  parameter int MAX_BYTES = DEF_MAX_BYTES,
  parameter int ADDR_W    = 8,
  parameter int MEM_LAT   = 1,
  parameter int RESET_PC  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          jump_valid,
  input  logic [ADDR_W-1:0]             jump_addr,
  output logic                          mem_rd,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [BYTE_W-1:0]             mem_data,
  output logic                          dec_start,
  input  logic                          dec_ready,
  output logic [MAX_BYTES*BYTE_W-1:0]   dec_instr,
  output logic [$clog2(MAX_BYTES):0]    dec_len,
  output logic [ADDR_W-1:0]             dec_pc
);

  localparam int IW = instr_width(BYTE_W, MAX_BYTES);
  localparam int LW = len_code_width(MAX_BYTES);
  localparam int CW = LW + 1;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     idx;
  logic              lat_done;

  logic [LW-1:0]     len_code;
  logic [CW-1:0]     new_len;
  logic [CW-1:0]     cur_len;
  logic [CW-1:0]     idx_next;
  logic              last_byte;
  logic [ADDR_W-1:0] pc_inc;

  assign len_code  = mem_data[BYTE_W-1 -: LW];
  assign new_len   = CW'(len_from_opcode(int'(len_code), MAX_BYTES));
  // On the opcode byte the stored length is stale, so use the fresh decode.
  assign cur_len   = (idx == '0) ? new_len : dec_len;
  assign idx_next  = idx + CW'(1);
  assign last_byte = (idx_next >= cur_len);
  assign pc_inc    = pc + ADDR_W'(1);

  ifu_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (state == FETCH && mem_rd),
    .flush    (jump_valid),
    .count_en (state == WAIT),
    .done     (lat_done)
  );

  // mem_rd is high for the single FETCH cycle that issues a read; when
  // entering FETCH from idle the strobe is raised one cycle later, but
  // between bytes of one instruction it is raised on the capture edge so
  // each byte costs exactly 1+MEM_LAT cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= ADDR_W'(RESET_PC);
      idx       <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      dec_start <= 1'b0;
      dec_instr <= '0;
      dec_len   <= '0;
      dec_pc    <= '0;
    end else if (jump_valid) begin
      state     <= FETCH;
      pc        <= jump_addr;
      idx       <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      dec_start <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_rd) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            state    <= WAIT;
          end else if (idx != '0 || enable) begin
            mem_rd   <= 1'b1;
            mem_addr <= pc;
          end
        end
        WAIT: begin
          if (lat_done) begin
            pc <= pc_inc;
            if (idx == '0) begin
              dec_instr <= {mem_data, {(IW-BYTE_W){1'b0}}};
              dec_len   <= new_len;
              dec_pc    <= pc;
            end else begin
              dec_instr[(MAX_BYTES-int'(idx))*BYTE_W-1 -: BYTE_W] <= mem_data;
            end
            if (last_byte) begin
              idx       <= '0;
              state     <= SEND;
              dec_start <= 1'b1;
            end else begin
              idx      <= idx_next;
              state    <= FETCH;
              mem_rd   <= 1'b1;
              mem_addr <= pc_inc;
            end
          end
        end
        SEND: begin
          if (dec_ready) begin
            dec_start <= 1'b0;
            idx       <= '0;
            state     <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
